// File: rtl/hello_ram_master.sv
// Avalon-MM fill/verify engine for the on-chip RAM s1 port.
// Define HELLO_RAM_MASTER_FAIL_CAPTURE_EN to add first-failure capture outputs.
module hello_ram_master #(
    parameter int ADDR_W       = 13,
    parameter int DATA_W       = 32,
    parameter int MAX_WORDS    = 5120,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_start,
    input  logic                cmd_mode,
    input  logic [ADDR_W-1:0]   cmd_base,
    input  logic [ADDR_W:0]     cmd_count,
    input  logic [DATA_W-1:0]   cmd_seed,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [ADDR_W-1:0]   avm_address,
    output logic [DATA_W/8-1:0] avm_byteenable,
    output logic                avm_chipselect,
    output logic                avm_write,
    output logic                avm_read,
    output logic [DATA_W-1:0]   avm_writedata,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_waitrequest
`ifdef HELLO_RAM_MASTER_FAIL_CAPTURE_EN
    ,
    output logic [ADDR_W:0]     fail_count,
    output logic [ADDR_W-1:0]   fail_addr,
    output logic [DATA_W-1:0]   fail_data
`endif
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = ADDR_W + 1;
    localparam int SUM_W = ADDR_W + 2;
    localparam logic [SUM_W-1:0] MAX_V = SUM_W'(MAX_WORDS);
    localparam int HEAD = READ_LATENCY - 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_WRITE, S_READ, S_DRAIN, S_FIN
    } state_t;

    state_t              state_q, state_d;
    logic                mode_q, mode_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [DATA_W-1:0]   seed_q, seed_d;
    logic [CNT_W-1:0]    rem_q, rem_d;
    logic [DATA_W-1:0]   pat_q, pat_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic                cs_q, cs_d;
    logic                wr_q, wr_d;
    logic                rd_q, rd_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    // Each entry tracks one accepted read until its data returns.
    logic [READ_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [DATA_W-1:0]       pipe_exp_q [READ_LATENCY];
    logic [DATA_W-1:0]       pipe_exp_d [READ_LATENCY];
`ifdef HELLO_RAM_MASTER_FAIL_CAPTURE_EN
    logic [ADDR_W-1:0]       pipe_addr_q [READ_LATENCY];
    logic [ADDR_W-1:0]       pipe_addr_d [READ_LATENCY];
    logic [CNT_W-1:0]        fail_count_q, fail_count_d;
    logic [ADDR_W-1:0]       fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0]       fail_data_q, fail_data_d;
`endif

    logic rd_accept;
    logic mismatch;
    logic rest_busy;

    assign rd_accept = (state_q == S_READ) && !avm_waitrequest;
    assign mismatch  = pipe_vld_q[HEAD] && (avm_readdata != pipe_exp_q[HEAD]);

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        base_d     = base_q;
        count_d    = count_q;
        seed_d     = seed_q;
        rem_d      = rem_q;
        pat_d      = pat_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = error_q;
        addr_d     = addr_q;
        be_d       = be_q;
        cs_d       = cs_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        wdata_d    = wdata_q;
        pipe_vld_d = '0;
        pipe_exp_d = pipe_exp_q;
        rest_busy  = 1'b0;
`ifdef HELLO_RAM_MASTER_FAIL_CAPTURE_EN
        pipe_addr_d  = pipe_addr_q;
        fail_count_d = fail_count_q;
        fail_addr_d  = fail_addr_q;
        fail_data_d  = fail_data_q;
        pipe_addr_d[0] = addr_q;
`endif

        pipe_vld_d[0] = rd_accept;
        pipe_exp_d[0] = pat_q;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_exp_d[i] = pipe_exp_q[i-1];
`ifdef HELLO_RAM_MASTER_FAIL_CAPTURE_EN
            pipe_addr_d[i] = pipe_addr_q[i-1];
`endif
        end
        for (int i = 0; i < READ_LATENCY - 1; i++) begin
            rest_busy = rest_busy | pipe_vld_q[i];
        end

        if (mismatch) begin
            error_d = 1'b1;
`ifdef HELLO_RAM_MASTER_FAIL_CAPTURE_EN
            if (fail_count_q == '0) begin
                fail_addr_d = pipe_addr_q[HEAD];
                fail_data_d = avm_readdata;
            end
            if (fail_count_q != '1) begin
                fail_count_d = fail_count_q + CNT_W'(1);
            end
`endif
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_start) begin
                    mode_d  = cmd_mode;
                    base_d  = cmd_base;
                    count_d = cmd_count;
                    seed_d  = cmd_seed;
                    error_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_CHECK;
`ifdef HELLO_RAM_MASTER_FAIL_CAPTURE_EN
                    fail_count_d = '0;
                    fail_addr_d  = '0;
                    fail_data_d  = '0;
`endif
                end
            end
            S_CHECK: begin
                if (SUM_W'(base_q) + SUM_W'(count_q) > MAX_V) begin
                    error_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_FIN;
                end else if (count_q == '0) begin
                    done_d  = 1'b1;
                    state_d = S_FIN;
                end else begin
                    addr_d = base_q;
                    pat_d  = seed_q;
                    rem_d  = count_q;
                    cs_d   = 1'b1;
                    be_d   = '1;
                    if (mode_q) begin
                        rd_d    = 1'b1;
                        state_d = S_READ;
                    end else begin
                        wr_d    = 1'b1;
                        wdata_d = seed_q;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE, S_READ: begin
                if (!avm_waitrequest) begin
                    if (rem_q == CNT_W'(1)) begin
                        addr_d  = '0;
                        be_d    = '0;
                        cs_d    = 1'b0;
                        wr_d    = 1'b0;
                        rd_d    = 1'b0;
                        wdata_d = '0;
                        if (state_q == S_WRITE) begin
                            done_d  = 1'b1;
                            state_d = S_FIN;
                        end else begin
                            state_d = S_DRAIN;
                        end
                    end else begin
                        rem_d  = rem_q - CNT_W'(1);
                        addr_d = addr_q + ADDR_W'(1);
                        pat_d  = pat_q + DATA_W'(1);
                        if (state_q == S_WRITE) begin
                            wdata_d = pat_q + DATA_W'(1);
                        end
                    end
                end
            end
            S_DRAIN: begin
                // Only the head may still be pending: its compare lands this cycle.
                if (!rest_busy) begin
                    done_d  = 1'b1;
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            mode_q     <= 1'b0;
            base_q     <= '0;
            count_q    <= '0;
            seed_q     <= '0;
            rem_q      <= '0;
            pat_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            cs_q       <= 1'b0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            wdata_q    <= '0;
            pipe_vld_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_exp_q[i] <= '0;
`ifdef HELLO_RAM_MASTER_FAIL_CAPTURE_EN
                pipe_addr_q[i] <= '0;
`endif
            end
`ifdef HELLO_RAM_MASTER_FAIL_CAPTURE_EN
            fail_count_q <= '0;
            fail_addr_q  <= '0;
            fail_data_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            base_q     <= base_d;
            count_q    <= count_d;
            seed_q     <= seed_d;
            rem_q      <= rem_d;
            pat_q      <= pat_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            cs_q       <= cs_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            wdata_q    <= wdata_d;
            pipe_vld_q <= pipe_vld_d;
            pipe_exp_q <= pipe_exp_d;
`ifdef HELLO_RAM_MASTER_FAIL_CAPTURE_EN
            pipe_addr_q  <= pipe_addr_d;
            fail_count_q <= fail_count_d;
            fail_addr_q  <= fail_addr_d;
            fail_data_q  <= fail_data_d;
`endif
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign avm_address    = addr_q;
    assign avm_byteenable = be_q;
    assign avm_chipselect = cs_q;
    assign avm_write      = wr_q;
    assign avm_read       = rd_q;
    assign avm_writedata  = wdata_q;
`ifdef HELLO_RAM_MASTER_FAIL_CAPTURE_EN
    assign fail_count = fail_count_q;
    assign fail_addr  = fail_addr_q;
    assign fail_data  = fail_data_q;
`endif

endmodule

// File: tb/tb_hello_ram_master.sv
// Self-checking bench for hello_ram_master: RAM model, bus monitor and
// per-scenario tasks compared against a pattern/range reference model.
module tb_hello_ram_master;

    localparam int AW   = 13;
    localparam int DW   = 32;
    localparam int MAXW = 5120;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_start = 1'b0;
    logic          cmd_mode = 1'b0;
    logic [AW-1:0] cmd_base = '0;
    logic [AW:0]   cmd_count = '0;
    logic [DW-1:0] cmd_seed = '0;
    logic          busy, done, error;
    logic [AW-1:0] avm_address;
    logic [3:0]    avm_byteenable;
    logic          avm_chipselect, avm_write, avm_read;
    logic [DW-1:0] avm_writedata;
    logic [DW-1:0] avm_readdata = '0;
    logic          avm_waitrequest = 1'b0;
`ifdef HELLO_RAM_MASTER_FAIL_CAPTURE_EN
    logic [AW:0]   fail_count;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_data;
    logic [AW:0]   t_fcount;
    logic [AW-1:0] t_faddr;
    logic [DW-1:0] t_fdata;
`endif

    hello_ram_master dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_start(cmd_start), .cmd_mode(cmd_mode), .cmd_base(cmd_base),
        .cmd_count(cmd_count), .cmd_seed(cmd_seed),
        .busy(busy), .done(done), .error(error),
        .avm_address(avm_address), .avm_byteenable(avm_byteenable),
        .avm_chipselect(avm_chipselect), .avm_write(avm_write), .avm_read(avm_read),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest)
`ifdef HELLO_RAM_MASTER_FAIL_CAPTURE_EN
        , .fail_count(fail_count), .fail_addr(fail_addr), .fail_data(fail_data)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nvec = 0;
    int nmis = 0;

    // RAM model, transfer log and bus-rule monitor.
    logic [DW-1:0] mem [0:MAXW-1];
    logic [AW-1:0] wr_addr_q [$];
    logic [DW-1:0] wr_data_q [$];
    int            wr_cyc_q  [$];
    logic [AW-1:0] rd_addr_q [$];
    int            rd_cyc_q  [$];
    int            bus_viol = 0;
    logic          rd_hit_n = 1'b0;
    logic [AW-1:0] rd_addr_n = '0;
    logic          prev_stall = 1'b0;
    logic          h_wr, h_rd;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_data;

    logic          stall_en = 1'b0;
    logic          corrupt_en = 1'b0;
    logic [AW-1:0] corrupt_addr = '0;
    logic [DW-1:0] corrupt_val = '0;

    always @(negedge clk) begin
        rd_hit_n = 1'b0;
        if (!reset_n) begin
            prev_stall = 1'b0;
        end else begin
            if (avm_read && avm_write) bus_viol++;
            if ((avm_read || avm_write) && (!avm_chipselect || avm_byteenable !== 4'hF)) bus_viol++;
            if (!(avm_read || avm_write) && avm_chipselect) bus_viol++;
            if (prev_stall && (avm_write !== h_wr || avm_read !== h_rd || avm_address !== h_addr ||
                               (h_wr && avm_writedata !== h_data))) bus_viol++;
            prev_stall = (avm_read || avm_write) && avm_waitrequest;
            h_wr = avm_write; h_rd = avm_read; h_addr = avm_address; h_data = avm_writedata;
            if (avm_write && !avm_waitrequest) begin
                wr_addr_q.push_back(avm_address);
                wr_data_q.push_back(avm_writedata);
                wr_cyc_q.push_back(cyc);
                mem[avm_address] = avm_writedata;
            end
            if (avm_read && !avm_waitrequest) begin
                rd_addr_q.push_back(avm_address);
                rd_cyc_q.push_back(cyc);
                rd_hit_n  = 1'b1;
                rd_addr_n = avm_address;
            end
        end
    end

    // One-cycle-latency slave: data only in the cycle after an accepted read.
    always @(posedge clk) begin
        #1;
        if (rd_hit_n)
            avm_readdata = (corrupt_en && rd_addr_n == corrupt_addr) ? corrupt_val : mem[rd_addr_n];
        else
            avm_readdata = $urandom;
        avm_waitrequest = stall_en ? ($urandom_range(0, 1) == 1) : 1'b0;
    end

    function automatic logic [DW-1:0] ram_word(input int a);
        return (corrupt_en && a == int'(corrupt_addr)) ? corrupt_val : mem[a];
    endfunction

    function automatic logic model_err(input logic mode, input int base, input int count,
                                       input logic [DW-1:0] seed);
        if (base + count > MAXW) return 1'b1;
        if (!mode) return 1'b0;
        for (int i = 0; i < count; i++) begin
            if (ram_word(base + i) !== seed + DW'(i)) return 1'b1;
        end
        return 1'b0;
    endfunction

    int   t_start, t_done, t_wr0, t_rd0, t_viol0;
    logic t_got, t_err;

    task automatic run_cmd(input logic mode, input logic [AW-1:0] base, input logic [AW:0] count,
                           input logic [DW-1:0] seed);
        t_wr0 = wr_addr_q.size(); t_rd0 = rd_addr_q.size(); t_viol0 = bus_viol;
        @(posedge clk); #1;
        cmd_mode = mode; cmd_base = base; cmd_count = count; cmd_seed = seed; cmd_start = 1'b1;
        t_start = cyc;
        @(posedge clk); #1;
        cmd_start = 1'b0;
        t_got = 1'b0; t_err = 1'b0; t_done = 0;
        for (int i = 0; i < 600 && !t_got; i++) begin
            @(negedge clk);
            if (done) begin
                t_got = 1'b1; t_done = cyc; t_err = error;
`ifdef HELLO_RAM_MASTER_FAIL_CAPTURE_EN
                t_fcount = fail_count; t_faddr = fail_addr; t_fdata = fail_data;
`endif
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        nvec++;
        if ({busy, done, error, avm_write, avm_read, avm_chipselect} !== 6'b0) begin
            nmis++; $display("FAIL reset_ctrl: got %b expected 000000",
                             {busy, done, error, avm_write, avm_read, avm_chipselect});
        end
        nvec++;
        if (avm_address !== '0 || avm_byteenable !== 4'h0 || avm_writedata !== '0) begin
            nmis++; $display("FAIL reset_bus: got addr %0h be %0h wd %0h expected all 0",
                             avm_address, avm_byteenable, avm_writedata);
        end
        @(posedge clk); #2 reset_n = 1'b1;
        repeat (3) @(negedge clk);
        nvec++;
        if ({busy, done, avm_chipselect} !== 3'b0) begin
            nmis++; $display("FAIL idle_after_reset: got %b expected 000", {busy, done, avm_chipselect});
        end
    endtask

    task automatic test_fill_basic();
        int n, last;
        stall_en = 1'b0;
        run_cmd(1'b0, 13'h10, 14'd4, 32'hFFFF_FFFE);
        n = wr_addr_q.size() - t_wr0;
        nvec++;
        if (!t_got) begin nmis++; $display("FAIL fill_done_timeout: got none expected done"); end
        nvec++;
        if (n != 4) begin nmis++; $display("FAIL fill_count: got %0d expected 4", n); end
        for (int i = 0; i < n && i < 4; i++) begin
            nvec++;
            if (wr_addr_q[t_wr0+i] !== 13'(16 + i) || wr_data_q[t_wr0+i] !== 32'hFFFF_FFFE + 32'(i) ||
                wr_cyc_q[t_wr0+i] != wr_cyc_q[t_wr0] + i) begin
                nmis++; $display("FAIL fill_word%0d: got %0h/%0h@%0d expected %0h/%0h@%0d", i,
                                 wr_addr_q[t_wr0+i], wr_data_q[t_wr0+i], wr_cyc_q[t_wr0+i],
                                 16 + i, 32'hFFFF_FFFE + 32'(i), wr_cyc_q[t_wr0] + i);
            end
        end
        last = (n > 0) ? wr_cyc_q[t_wr0+n-1] : -10;
        nvec++;
        if (t_done != last + 1) begin nmis++; $display("FAIL fill_done_cycle: got %0d expected %0d", t_done, last + 1); end
        nvec++;
        if (t_err !== 1'b0) begin nmis++; $display("FAIL fill_error: got %b expected 0", t_err); end
        nvec++;
        if (rd_addr_q.size() != t_rd0 || bus_viol != t_viol0) begin
            nmis++; $display("FAIL fill_bus_rules: got %0d reads %0d viol expected 0 0",
                             rd_addr_q.size() - t_rd0, bus_viol - t_viol0);
        end
        nvec++;
        if (busy !== 1'b0) begin nmis++; $display("FAIL fill_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_verify(input logic do_corrupt);
        int n, last; logic exp_e;
        stall_en = 1'b0;
        corrupt_en = do_corrupt; corrupt_addr = 13'h12; corrupt_val = 32'hDEAD_BEEF;
        exp_e = model_err(1'b1, 16, 4, 32'hFFFF_FFFE);
        run_cmd(1'b1, 13'h10, 14'd4, 32'hFFFF_FFFE);
        n = rd_addr_q.size() - t_rd0;
        nvec++;
        if (!t_got || n != 4) begin nmis++; $display("FAIL verify_reads: got %0d (done %b) expected 4", n, t_got); end
        for (int i = 0; i < n && i < 4; i++) begin
            nvec++;
            if (rd_addr_q[t_rd0+i] !== 13'(16 + i) || rd_cyc_q[t_rd0+i] != rd_cyc_q[t_rd0] + i) begin
                nmis++; $display("FAIL verify_rd%0d: got %0h@%0d expected %0h@%0d", i, rd_addr_q[t_rd0+i],
                                 rd_cyc_q[t_rd0+i], 16 + i, rd_cyc_q[t_rd0] + i);
            end
        end
        last = (n > 0) ? rd_cyc_q[t_rd0+n-1] : -10;
        nvec++;
        if (t_done != last + 2) begin nmis++; $display("FAIL verify_done_cycle: got %0d expected %0d", t_done, last + 2); end
        nvec++;
        if (t_err !== exp_e) begin nmis++; $display("FAIL verify_error: got %b expected %b", t_err, exp_e); end
`ifdef HELLO_RAM_MASTER_FAIL_CAPTURE_EN
        nvec++;
        if (do_corrupt && (t_fcount !== 14'd1 || t_faddr !== 13'h12 || t_fdata !== 32'hDEAD_BEEF)) begin
            nmis++; $display("FAIL fail_capture: got %0d/%0h/%0h expected 1/12/deadbeef", t_fcount, t_faddr, t_fdata);
        end
`endif
        corrupt_en = 1'b0;
    endtask

    task automatic test_fill_stall();
        logic [AW-1:0] b; logic [DW-1:0] s; int n;
        b = 13'($urandom_range(0, 5000)); s = $urandom;
        stall_en = 1'b1;
        run_cmd(1'b0, b, 14'd16, s);
        n = wr_addr_q.size() - t_wr0;
        nvec++;
        if (!t_got || n != 16) begin nmis++; $display("FAIL stall_fill_count: got %0d expected 16", n); end
        for (int i = 0; i < n && i < 16; i++) begin
            nvec++;
            if (wr_addr_q[t_wr0+i] !== b + 13'(i) || wr_data_q[t_wr0+i] !== s + 32'(i)) begin
                nmis++; $display("FAIL stall_fill_word%0d: got %0h/%0h expected %0h/%0h", i,
                                 wr_addr_q[t_wr0+i], wr_data_q[t_wr0+i], b + 13'(i), s + 32'(i));
            end
        end
        nvec++;
        if (bus_viol != t_viol0) begin nmis++; $display("FAIL stall_hold: got %0d violations expected 0", bus_viol - t_viol0); end
        nvec++;
        if (n > 0 && t_done != wr_cyc_q[t_wr0+n-1] + 1) begin
            nmis++; $display("FAIL stall_done_cycle: got %0d expected %0d", t_done, wr_cyc_q[t_wr0+n-1] + 1);
        end
        run_cmd(1'b1, b, 14'd16, s);
        n = rd_addr_q.size() - t_rd0;
        nvec++;
        if (!t_got || n != 16 || t_err !== 1'b0 || bus_viol != t_viol0) begin
            nmis++; $display("FAIL stall_verify: got %0d reads err %b viol %0d expected 16 0 0",
                             n, t_err, bus_viol - t_viol0);
        end
        stall_en = 1'b0;
    endtask

    task automatic test_boundary();
        logic [DW-1:0] s;
        s = $urandom;
        run_cmd(1'b0, 13'd5119, 14'd1, s);
        nvec++;
        if (wr_addr_q.size() - t_wr0 != 1 || wr_addr_q[wr_addr_q.size()-1] !== 13'd5119 || t_err !== 1'b0) begin
            nmis++; $display("FAIL last_word_fill: got %0d writes err %b expected 1 write to 5119 err 0",
                             wr_addr_q.size() - t_wr0, t_err);
        end
        run_cmd(1'b1, 13'd5119, 14'd1, s);
        nvec++;
        if (rd_addr_q.size() - t_rd0 != 1 || t_err !== 1'b0) begin
            nmis++; $display("FAIL last_word_verify: got %0d reads err %b expected 1 0", rd_addr_q.size() - t_rd0, t_err);
        end
        run_cmd(1'b0, 13'd5119, 14'd2, s);
        nvec++;
        if (t_done - t_start != 2 || t_err !== 1'b1 || wr_addr_q.size() != t_wr0) begin
            nmis++; $display("FAIL reject_range: got lat %0d err %b writes %0d expected 2 1 0",
                             t_done - t_start, t_err, wr_addr_q.size() - t_wr0);
        end
        run_cmd(1'b1, 13'd40, 14'd0, s);
        nvec++;
        if (t_done - t_start != 2 || t_err !== 1'b0 || rd_addr_q.size() != t_rd0) begin
            nmis++; $display("FAIL count_zero: got lat %0d err %b reads %0d expected 2 0 0",
                             t_done - t_start, t_err, rd_addr_q.size() - t_rd0);
        end
        run_cmd(1'b0, 13'd5108, 14'd12, s);
        nvec++;
        if (wr_addr_q.size() - t_wr0 != 12 || t_err !== 1'b0) begin
            nmis++; $display("FAIL exact_end_range: got %0d writes err %b expected 12 0", wr_addr_q.size() - t_wr0, t_err);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            logic [AW-1:0] b; logic [AW:0] c; logic [DW-1:0] s; logic exp_e; int n, off;
            stall_en = ($urandom_range(0, 1) == 1);
            b = 13'($urandom_range(0, 5100)); c = 14'($urandom_range(1, 12)); s = $urandom;
            run_cmd(1'b0, b, c, s);
            n = wr_addr_q.size() - t_wr0;
            nvec++;
            if (!t_got || n != int'(c) || t_err !== 1'b0) begin
                nmis++; $display("FAIL rand_fill%0d: got %0d writes err %b expected %0d 0", it, n, t_err, c);
            end
            for (int i = 0; i < n && i < int'(c); i++) begin
                nvec++;
                if (wr_addr_q[t_wr0+i] !== b + 13'(i) || wr_data_q[t_wr0+i] !== s + 32'(i)) begin
                    nmis++; $display("FAIL rand_fill%0d_word%0d: got %0h/%0h expected %0h/%0h", it, i,
                                     wr_addr_q[t_wr0+i], wr_data_q[t_wr0+i], b + 13'(i), s + 32'(i));
                end
            end
            if ($urandom_range(0, 1) == 1) begin
                off = $urandom_range(0, int'(c) - 1);
                corrupt_addr = b + 13'(off); corrupt_val = ~(s + 32'(off)); corrupt_en = 1'b1;
            end
            exp_e = model_err(1'b1, int'(b), int'(c), s);
            run_cmd(1'b1, b, c, s);
            n = rd_addr_q.size() - t_rd0;
            nvec++;
            if (!t_got || n != int'(c) || t_err !== exp_e) begin
                nmis++; $display("FAIL rand_verify%0d: got %0d reads err %b expected %0d %b", it, n, t_err, c, exp_e);
            end
            nvec++;
            if (n > 0 && t_done != rd_cyc_q[t_rd0+n-1] + 2) begin
                nmis++; $display("FAIL rand_verify%0d_done: got %0d expected %0d", it, t_done, rd_cyc_q[t_rd0+n-1] + 2);
            end
            corrupt_en = 1'b0;
        end
        stall_en = 1'b0;
        run_cmd(1'b1, 13'($urandom_range(5100, 5119)), 14'($urandom_range(21, 60)), $urandom);
        nvec++;
        if (t_done - t_start != 2 || t_err !== 1'b1 || rd_addr_q.size() != t_rd0) begin
            nmis++; $display("FAIL rand_reject: got lat %0d err %b reads %0d expected 2 1 0",
                             t_done - t_start, t_err, rd_addr_q.size() - t_rd0);
        end
    endtask

    task automatic test_reset_mid_read();
        logic [DW-1:0] s; int r0; logic seen;
        s = $urandom;
        stall_en = 1'b0;
        run_cmd(1'b0, 13'h200, 14'd8, s);
        r0 = rd_addr_q.size();
        @(posedge clk); #1;
        cmd_mode = 1'b1; cmd_base = 13'h200; cmd_count = 14'd8; cmd_seed = s; cmd_start = 1'b1;
        @(posedge clk); #1;
        cmd_start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (rd_addr_q.size() - r0 >= 2) seen = 1'b1;
        end
        nvec++;
        if (!seen) begin nmis++; $display("FAIL midread_no_reads: got %0d reads expected 2", rd_addr_q.size() - r0); end
        #2 reset_n = 1'b0;
        #1;
        nvec++;
        if ({avm_read, avm_write, avm_chipselect, busy, done} !== 5'b0 || avm_address !== '0 || avm_byteenable !== 4'h0) begin
            nmis++; $display("FAIL midread_reset_outputs: got %b addr %0h be %0h expected 0",
                             {avm_read, avm_write, avm_chipselect, busy, done}, avm_address, avm_byteenable);
        end
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (3) @(negedge clk);
        nvec++;
        if (error !== 1'b0 || busy !== 1'b0) begin
            nmis++; $display("FAIL stale_compare: got err %b busy %b expected 0 0", error, busy);
        end
        run_cmd(1'b1, 13'h200, 14'd8, s);
        nvec++;
        if (!t_got || rd_addr_q.size() - t_rd0 != 8 || t_err !== 1'b0) begin
            nmis++; $display("FAIL restart_verify: got %0d reads err %b expected 8 0", rd_addr_q.size() - t_rd0, t_err);
        end
    endtask

    initial begin
        test_reset();
        test_fill_basic();
        test_verify(1'b0);
        test_verify(1'b1);
        test_fill_stall();
        test_boundary();
        test_random();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
